// File: rtl/vec_exec_unit.sv
// -----------------------------------------------------------------------------
// vec_exec_unit
//
// Multi-cycle vector execute stage sitting right after the register file.
// An issued operation latches its operands, walks the 24 lanes in BEATS beats
// of LPC lanes each, and then presents the result together with the
// destination index and write strobe for the register-file write port.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active low
//   start      in   issue request, only looked at while idle
//   op         in   operation code (3 b)
//   dest       in   destination register index (3 b)
//   r1e        in   scalar operand (21 b); only bits [7:0] are consumed
//   r1v, r2v   in   vector operands (LANES x LANE_W)
//   busy       out  high from the cycle after accept until done rises
//   done       out  one-cycle pulse, results valid
//   wd3v       out  vector result
//   wd3e       out  scalar result (lane sum)
//   A3         out  destination index
//   Reg_write  out  write strobe (done, except for the reserved op)
//   desType    out  0 = scalar result, 1 = vector result
//
// Optional feature
//   VEC_SATURATE_EN : when defined, VADD/VADDS clamp lanes to all-ones on
//   carry out and VSUB clamps to zero on borrow; otherwise lanes wrap.
// -----------------------------------------------------------------------------
module vec_exec_unit #(
    parameter int LANE_W = 8,
    parameter int LANES  = 24,
    parameter int LPC    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [2:0]                op,
    input  logic [2:0]                dest,
    input  logic [20:0]               r1e,
    input  logic [LANE_W*LANES-1:0]   r1v,
    input  logic [LANE_W*LANES-1:0]   r2v,
    output logic                      busy,
    output logic                      done,
    output logic [LANE_W*LANES-1:0]   wd3v,
    output logic [20:0]               wd3e,
    output logic [2:0]                A3,
    output logic                      Reg_write,
    output logic                      desType
);

    localparam int VEC_W  = LANE_W * LANES;
    localparam int BEATS  = LANES / LPC;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [2:0] OP_VADD  = 3'b000;
    localparam logic [2:0] OP_VSUB  = 3'b001;
    localparam logic [2:0] OP_VXOR  = 3'b010;
    localparam logic [2:0] OP_VAND  = 3'b011;
    localparam logic [2:0] OP_VADDS = 3'b100;
    localparam logic [2:0] OP_VSHL  = 3'b101;
    localparam logic [2:0] OP_VSUM  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t                state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  busy_q, done_q, rw_q, des_q;
    logic [2:0]            a3_q;
    logic [VEC_W-1:0]      wd3v_q;
    logic [20:0]           wd3e_q;

    // Latched operands and running results
    logic [2:0]            op_q, dest_q;
    logic [LANE_W-1:0]     r1e_q;
    logic [VEC_W-1:0]      r1v_q, r2v_q;
    logic [VEC_W-1:0]      acc_q, acc_d;
    logic [20:0]           sum_q, sum_d;
    int                    lane_base;

    // Only the low byte of the scalar operand is architecturally consumed.
    logic                  unused_r1e;
    assign unused_r1e = ^r1e[20:LANE_W];

    function automatic logic [LANE_W-1:0] add_lane(input logic [LANE_W-1:0] a,
                                                    input logic [LANE_W-1:0] b);
`ifdef VEC_SATURATE_EN
        logic [LANE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LANE_W] ? {LANE_W{1'b1}} : s[LANE_W-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [LANE_W-1:0] sub_lane(input logic [LANE_W-1:0] a,
                                                    input logic [LANE_W-1:0] b);
`ifdef VEC_SATURATE_EN
        logic [LANE_W:0] s;
        s = {1'b0, a} - {1'b0, b};
        return s[LANE_W] ? {LANE_W{1'b0}} : s[LANE_W-1:0];
`else
        return a - b;
`endif
    endfunction

    function automatic logic [LANE_W-1:0] lane_op(input logic [2:0]        o,
                                                   input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b,
                                                   input logic [LANE_W-1:0] s);
        case (o)
            OP_VADD:  return add_lane(a, b);
            OP_VSUB:  return sub_lane(a, b);
            OP_VXOR:  return a ^ b;
            OP_VAND:  return a & b;
            OP_VADDS: return add_lane(b, s);
            OP_VSHL:  return b << s[2:0];
            default:  return '0;
        endcase
    endfunction

    // Lane slice for the current beat: lanes [beat*LPC, beat*LPC+LPC-1]
    always_comb begin
        acc_d     = acc_q;
        sum_d     = sum_q;
        lane_base = 0;
        for (int l = 0; l < LPC; l++) begin
            lane_base = (int'(beat_q) * LPC + l) * LANE_W;
            acc_d[lane_base +: LANE_W] = lane_op(op_q,
                                                 r1v_q[lane_base +: LANE_W],
                                                 r2v_q[lane_base +: LANE_W],
                                                 r1e_q);
            sum_d = sum_d + 21'(r2v_q[lane_base +: LANE_W]);
        end
    end

    // Operand latch / beat accumulation (no reset needed: always overwritten
    // on accept before use)
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            op_q   <= op;
            dest_q <= dest;
            r1e_q  <= r1e[LANE_W-1:0];
            r1v_q  <= r1v;
            r2v_q  <= r2v;
            acc_q  <= '0;
            sum_q  <= '0;
        end else if (state_q == S_EXEC) begin
            acc_q  <= acc_d;
            sum_q  <= sum_d;
        end
    end

    // Control FSM with registered outputs. The result registers update on the
    // DONE->IDLE edge, so done is seen in the IDLE cycle and a start in that
    // same cycle is accepted (back-to-back period BEATS+2).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rw_q    <= 1'b0;
            des_q   <= 1'b0;
            a3_q    <= '0;
            wd3v_q  <= '0;
            wd3e_q  <= '0;
        end else begin
            done_q <= 1'b0;
            rw_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    // Reserved op completes silently: no strobe, no result
                    if (op_q != OP_RSVD) begin
                        rw_q <= 1'b1;
                        a3_q <= dest_q;
                        if (op_q == OP_VSUM) begin
                            wd3e_q <= sum_q;
                            des_q  <= 1'b0;
                        end else begin
                            wd3v_q <= acc_q;
                            des_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Reg_write = rw_q;
    assign desType   = des_q;
    assign A3        = a3_q;
    assign wd3v      = wd3v_q;
    assign wd3e      = wd3e_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Testbench for vec_exec_unit: directed vectors, a lane-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_vec_exec_unit;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [2:0]   dest;
    logic [20:0]  r1e;
    logic [191:0] r1v;
    logic [191:0] r2v;
    logic         busy;
    logic         done;
    logic [191:0] wd3v;
    logic [20:0]  wd3e;
    logic [2:0]   A3;
    logic         Reg_write;
    logic         desType;

    int checks = 0;
    int errors = 0;

    vec_exec_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .dest      (dest),
        .r1e       (r1e),
        .r1v       (r1v),
        .r2v       (r2v),
        .busy      (busy),
        .done      (done),
        .wd3v      (wd3v),
        .wd3e      (wd3e),
        .A3        (A3),
        .Reg_write (Reg_write),
        .desType   (desType)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] fill(input logic [7:0] v);
        return {24{v}};
    endfunction

    function automatic logic [191:0] pat(input int k);
        logic [191:0] r;
        int v;
        r = '0;
        for (int i = 0; i < 24; i++) begin
            v = (i * k + 3 * i + 7 * k + 1) & 255;
            r[8*i +: 8] = v[7:0];
        end
        return r;
    endfunction

    // Reference: whole-vector result computed lane by lane with integer math
    function automatic logic [191:0] model_vec(input logic [2:0] o, input logic [20:0] e,
                                               input logic [191:0] a, input logic [191:0] b);
        logic [191:0] r;
        int x, y, s;
        r = '0;
        for (int i = 0; i < 24; i++) begin
            x = int'(a[8*i +: 8]);
            y = int'(b[8*i +: 8]);
            case (o)
                3'd0: s = x + y;
                3'd1: s = x - y;
                3'd2: s = x ^ y;
                3'd3: s = x & y;
                3'd4: s = y + int'(e[7:0]);
                3'd5: s = y << int'(e[2:0]);
                default: s = 0;
            endcase
`ifdef VEC_SATURATE_EN
            if ((o == 3'd0 || o == 3'd4) && s > 255) s = 255;
            if (o == 3'd1 && s < 0) s = 0;
`endif
            r[8*i +: 8] = s[7:0];
        end
        return r;
    endfunction

    function automatic logic [20:0] model_sum(input logic [191:0] b);
        int t;
        t = 0;
        for (int i = 0; i < 24; i++) t += int'(b[8*i +: 8]);
        return 21'(t);
    endfunction

    // Model state: expected outputs and a countdown to completion
    bit           m_valid = 0;
    int           pending = 0;
    logic [2:0]   m_op, m_dest;
    logic [191:0] m_v;
    logic [20:0]  m_e;
    logic         e_busy, e_done, e_rw, e_des;
    logic [2:0]   e_a3;
    logic [191:0] e_v;
    logic [20:0]  e_e;

    // Compare, then step the model with the inputs the next edge will sample
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("Reg_write", Reg_write, e_rw);
                chk("desType", desType, e_des);
                chk("A3", A3, e_a3);
                chk("wd3v", wd3v, e_v);
                chk("wd3e", wd3e, e_e);
            end
            if (rst_n === 1'b0) begin
                m_valid = 1;
                pending = 0;
                e_busy = 0; e_done = 0; e_rw = 0; e_des = 0;
                e_a3 = '0; e_v = '0; e_e = '0;
            end else if (m_valid) begin
                e_done = 0;
                e_rw   = 0;
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        e_busy = 0;
                        e_done = 1;
                        if (m_op != 3'd7) begin
                            e_rw = 1;
                            e_a3 = m_dest;
                            if (m_op == 3'd6) begin
                                e_e = m_e; e_des = 0;
                            end else begin
                                e_v = m_v; e_des = 1;
                            end
                        end
                    end
                end else if (start === 1'b1) begin
                    pending = 4;   // BEATS + 1 edges from accept to done
                    e_busy  = 1;
                    m_op    = op;
                    m_dest  = dest;
                    m_v     = model_vec(op, r1e, r1v, r2v);
                    m_e     = model_sum(r2v);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [20:0] e,
                         input logic [191:0] a, input logic [191:0] b);
        @(posedge clk); #1;
        op = o; dest = d; r1e = e; r1v = a; r2v = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // operands are free to change once accepted
        r1v = ~a; r2v = ~b; r1e = ~e; op = ~o; dest = ~d;
    endtask

    task automatic wait_done(input string name, output int n, output int bc);
        bit got;
        n = 0; bc = 0; got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i; got = 1;
                break;
            end
            if (busy === 1'b1) bc++;
        end
        if (!got) chk({name, "_done_seen"}, 0, 1);
    endtask

    int n, bc, cnt, first_c, second_c;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; dest = '0; r1e = '0; r1v = '0; r2v = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wd3v", wd3v, 0);
        chk("rst_A3", A3, 0);

        // VADD, latency and busy window
        issue(3'd0, 3'd5, 21'd0, fill(8'h10), fill(8'h05));
        wait_done("vadd", n, bc);
        chk("vadd_latency", n - 1, 4);
        chk("vadd_busy_cycles", bc, 4);
        chk("vadd_wd3v", wd3v, fill(8'h15));
        chk("vadd_A3", A3, 5);
        chk("vadd_rw", Reg_write, 1);
        chk("vadd_des", desType, 1);

        // VSUM of all-0xFF lanes; vector result left untouched
        issue(3'd6, 3'd2, 21'd0, pat(3), fill(8'hFF));
        wait_done("vsum", n, bc);
        chk("vsum_wd3e", wd3e, 21'd6120);
        chk("vsum_des", desType, 0);
        chk("vsum_A3", A3, 2);
        chk("vsum_wd3v_kept", wd3v, fill(8'h15));

        issue(3'd0, 3'd1, 21'd0, fill(8'hF0), fill(8'h20));
        wait_done("vadd_ovf", n, bc);
`ifdef VEC_SATURATE_EN
        chk("vadd_ovf", wd3v, fill(8'hFF));
`else
        chk("vadd_ovf", wd3v, fill(8'h10));
`endif

        issue(3'd1, 3'd3, 21'd0, fill(8'h01), fill(8'h02));
        wait_done("vsub_unf", n, bc);
`ifdef VEC_SATURATE_EN
        chk("vsub_unf", wd3v, fill(8'h00));
`else
        chk("vsub_unf", wd3v, fill(8'hFF));
`endif

        issue(3'd4, 3'd4, 21'h1ABC10, pat(1), fill(8'hFA));
        wait_done("vadds", n, bc);
`ifdef VEC_SATURATE_EN
        chk("vadds", wd3v, fill(8'hFF));
`else
        chk("vadds", wd3v, fill(8'h0A));
`endif

        issue(3'd5, 3'd6, 21'h0000FB, pat(2), fill(8'h81));
        wait_done("vshl", n, bc);
        chk("vshl", wd3v, fill(8'h08));

        issue(3'd2, 3'd7, 21'd0, pat(5), pat(9));
        wait_done("vxor", n, bc);
        issue(3'd3, 3'd0, 21'd0, pat(11), pat(4));
        wait_done("vand", n, bc);
        issue(3'd1, 3'd1, 21'd0, pat(13), pat(6));
        wait_done("vsub_pat", n, bc);
        issue(3'd0, 3'd2, 21'd0, pat(7), pat(8));
        wait_done("vadd_pat", n, bc);

        // start pulsed mid-EXEC is dropped
        issue(3'd2, 3'd3, 21'd0, pat(2), pat(3));
        @(posedge clk); #1 start = 1'b1; op = 3'd0;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("collide_one_done", cnt, 1);

        // start held high: accepted at edge 0, ignored while busy, re-accepted
        // in the cycle done is visible
        @(posedge clk); #1;
        op = 3'd0; dest = 3'd1; r1v = pat(1); r2v = pat(2); start = 1'b1;
        cnt = 0; first_c = -1; second_c = -1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin op = 3'd3; dest = 3'd4; r1v = pat(10); r2v = pat(12); end
            if (c == 5) start = 1'b0;
            #2;
            if (done === 1'b1) begin
                cnt++;
                if (first_c < 0) first_c = c; else second_c = c;
            end
        end
        chk("b2b_count", cnt, 2);
        chk("b2b_first", first_c, 4);
        chk("b2b_second", second_c, 9);

        // reset in the second EXEC cycle aborts without a strobe
        issue(3'd2, 3'd5, 21'd0, pat(3), pat(4));
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || Reg_write === 1'b1) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        chk("abort_wd3v", wd3v, 0);
        chk("abort_busy", busy, 0);

        issue(3'd7, 3'd6, 21'd0, pat(1), pat(2));
        wait_done("rsvd", n, bc);
        chk("rsvd_rw", Reg_write, 0);
        chk("rsvd_wd3v", wd3v, 0);
        chk("rsvd_A3", A3, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_exec_unit.md
Name: vec_exec_unit

Overview:
- Multi-cycle vector execute stage directly downstream of the register file.
- Consumes the scalar operand r1e (21 b) and the vector operands r1v/r2v (192 b = 24 lanes x 8 b).
- Produces the write-back data (wd3v or wd3e), the destination index and the write enable that feed back into the register file write port.
- Processes LPC lanes per cycle, so a full vector takes LANES/LPC beats.

Parameters:
- LANE_W, 8, bits per lane
- LANES, 24, lanes per vector (LANE_W*LANES = 192)
- LPC, 8, lanes processed per cycle; must divide LANES (BEATS = LANES/LPC = 3)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  issue request; sampled only in IDLE
- op  in  3  operation code
- dest  in  3  destination register index
- r1e  in  21  scalar operand
- r1v  in  192  vector operand 1
- r2v  in  192  vector operand 2
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the result is valid
- wd3v  out  192  vector result
- wd3e  out  21  scalar result
- A3  out  3  destination index, registered
- Reg_write  out  1  write strobe, equal to done except for reserved op
- desType  out  1  0 = scalar result, 1 = vector result

Behaviour:

Reset:
- rst_n = 0 at a clk edge forces state IDLE.
- Clears busy, done, Reg_write, desType, A3, wd3v and wd3e to 0.
- Reset mid-operation aborts; no write strobe is ever issued for the aborted op.

FSM states: IDLE, EXEC, DONE.
- IDLE: when start = 1, latch op, dest, r1e, r1v and r2v into internal registers, clear the accumulator and beat counter, and go to EXEC.
  - Operands may change after the accept cycle.
- EXEC: each cycle process lanes [beat*LPC, beat*LPC+LPC-1] from the latched operands, then beat++.
  - After beat BEATS-1 go to DONE.
- DONE: for one cycle assert done, assert Reg_write (unless op = 111) and hold wd3v/wd3e/A3/desType valid; then go to IDLE.
  - Results stay held until the next accept.
- start during EXEC or DONE is ignored; it is not queued.
- start = 1 in the IDLE cycle right after DONE is accepted, giving a back-to-back period of BEATS+2 cycles.
- Latency: start accepted at edge N; done is high in the cycle after edge N+BEATS+1, i.e. 4 cycles later with defaults.

Ops (lane i = bits [8i+7:8i], lane arithmetic modulo 2^LANE_W):
- 000 VADD: r1v + r2v
- 001 VSUB: r1v - r2v
- 010 VXOR: r1v ^ r2v
- 011 VAND: r1v & r2v
- 100 VADDS: r2v + r1e[7:0], scalar broadcast to every lane
- 101 VSHL: r2v << r1e[2:0] per lane; zero fill, bits shifted past the lane MSB are lost
- 110 VSUM: wd3e = zero-extended sum of all 24 r2v lanes; maximum 6120, no overflow in 21 b
  - desType = 0; wd3v is left unchanged
- 111 reserved: runs the full beat sequence and pulses done, but Reg_write = 0 and results are unchanged.

Output rules:
- desType = 1 for ops 000-101.
- desType = 0 for op 110.
- For op 111, desType keeps its previous value.

Optional Feature:
- Macro: VEC_SATURATE_EN.
- Defined: VADD and VADDS clamp each lane to 255 on carry out; VSUB clamps to 0 on borrow.
- Not defined: all lane arithmetic wraps modulo 256.
- XOR, AND, SHL and SUM are unaffected either way.

Test Plan:
- Reset then idle: hold rst_n = 0 for 2 cycles, then release -> all outputs 0, busy = 0 with no start.
- VADD timing: start with op=000, dest=5, r1v lanes all 0x10, r2v lanes all 0x05 -> done pulse exactly 4 cycles after accept, wd3v = 24 lanes of 0x15, A3 = 5, Reg_write = 1, desType = 1; busy high for the 3 EXEC cycles plus the DONE cycle.
- Wrap vs saturate: VADD with lanes 0xF0 + 0x20 -> 0x10 without VEC_SATURATE_EN, 0xFF with it. VSUB 0x01 - 0x02 -> 0xFF without, 0x00 with.
- VSUM: r2v with all lanes 0xFF, op=110, dest=2 -> wd3e = 21'd6120, desType = 0, wd3v unchanged from the previous op.
- Collisions: start pulsed during EXEC -> ignored, exactly one done. start in the IDLE cycle right after DONE -> accepted, next done BEATS+2 cycles after the first.
- Abort: rst_n = 0 in the second EXEC cycle of VXOR -> no done or Reg_write pulse, outputs 0. The next start/op=111 gives a done pulse with Reg_write = 0.
